// File: rtl/uc_fsm_if.sv
// uc_fsm_if: control bus between the micro-controller sequencer and its
// program counter, memory and datapath.
//   ce        : clock enable, shared with the program counter
//   data_in   : memory read data, [7:6] opcode, [5:0] operand address
//   carry     : registered carry flag from the datapath
//   clear_PC, load_PC, enable_PC : program-counter controls
//   ADR_JUMP  : jump / operand address, drives program-counter ADR_IN
//   sel_adr   : memory address mux, 0 = PC, 1 = ADR_JUMP
//   mem_ce, mem_we : memory enable / write strobe
//   load_accu, load_carry, init_carry, sel_ual : datapath controls
//   step, halted : single-step handshake, present only with UC_FSM_STEP_EN
// master modport is the sequencer side, slave modport the controlled side.
interface uc_fsm_if;
    logic       ce;
    logic [7:0] data_in;
    logic       carry;
    logic       clear_PC;
    logic       load_PC;
    logic       enable_PC;
    logic [5:0] ADR_JUMP;
    logic       sel_adr;
    logic       mem_ce;
    logic       mem_we;
    logic       load_accu;
    logic       load_carry;
    logic       init_carry;
    logic       sel_ual;
`ifdef UC_FSM_STEP_EN
    logic       step;
    logic       halted;
`endif
    modport master (
        input  ce, data_in, carry,
`ifdef UC_FSM_STEP_EN
        input  step,
        output halted,
`endif
        output clear_PC, load_PC, enable_PC, ADR_JUMP, sel_adr,
        output mem_ce, mem_we, load_accu, load_carry, init_carry, sel_ual
    );
    modport slave (
        output ce, data_in, carry,
`ifdef UC_FSM_STEP_EN
        output step,
        input  halted,
`endif
        input  clear_PC, load_PC, enable_PC, ADR_JUMP, sel_adr,
        input  mem_ce, mem_we, load_accu, load_carry, init_carry, sel_ual
    );
endinterface

// File: rtl/uc_fsm.sv
// uc_fsm: instruction sequencer of a 4-opcode accumulator micro-controller
// (00 NOR, 01 ADD, 10 STA, 11 JCC).
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, forces INIT and IR = 0
//   bus : uc_fsm_if.master, all datapath / memory / PC controls
// Optional macro UC_FSM_STEP_EN adds bus.step / bus.halted: the machine waits
// in FETCH_INS until step is high, reporting halted while it waits.
module uc_fsm (
    input  logic     clk,
    input  logic     rst,
    uc_fsm_if.master bus
);
    typedef enum logic [2:0] {
        INIT, FETCH_INS, DECODE, FETCH_OP, EXE_UAL, EXE_STA, EXE_JCC
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] ir_q;
    logic       clr, lpc, epc, sa, mce, mwe, lacc, lcy, icy, sual, hlt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            ir_q    <= 8'h00;
        end else if (bus.ce) begin
            state_q <= state_d;
            if (state_q == DECODE) ir_q <= bus.data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        lpc     = 1'b0;
        epc     = 1'b0;
        sa      = 1'b0;
        mce     = 1'b0;
        mwe     = 1'b0;
        lacc    = 1'b0;
        lcy     = 1'b0;
        icy     = 1'b0;
        sual    = 1'b0;
        hlt     = 1'b0;
        case (state_q)
            INIT: begin
                clr     = 1'b1;
                epc     = 1'b1;
                icy     = 1'b1;
                state_d = FETCH_INS;
            end
            FETCH_INS: begin
`ifdef UC_FSM_STEP_EN
                hlt     = ~bus.step;
                mce     = bus.step;
                state_d = bus.step ? DECODE : FETCH_INS;
`else
                mce     = 1'b1;
                state_d = DECODE;
`endif
            end
            DECODE: begin
                epc     = 1'b1;
                state_d = bus.data_in[7] ? (bus.data_in[6] ? EXE_JCC : EXE_STA) : FETCH_OP;
            end
            FETCH_OP: begin
                sa      = 1'b1;
                mce     = 1'b1;
                state_d = EXE_UAL;
            end
            // IR[7] is 0 here, so IR[6] alone tells ADD from NOR
            EXE_UAL: begin
                lacc    = 1'b1;
                lcy     = ir_q[6];
                sual    = ir_q[6];
                state_d = FETCH_INS;
            end
            EXE_STA: begin
                sa      = 1'b1;
                mce     = 1'b1;
                mwe     = 1'b1;
                state_d = FETCH_INS;
            end
            // jump when carry clear, otherwise consume the carry
            EXE_JCC: begin
                lpc     = ~bus.carry;
                icy     = bus.carry;
                state_d = FETCH_INS;
            end
            default: state_d = INIT;
        endcase
    end

    // strobes are suppressed while ce is low; address selects stay visible
    assign bus.clear_PC   = clr  & bus.ce;
    assign bus.load_PC    = lpc  & bus.ce;
    assign bus.enable_PC  = epc  & bus.ce;
    assign bus.mem_ce     = mce  & bus.ce;
    assign bus.mem_we     = mwe  & bus.ce;
    assign bus.load_accu  = lacc & bus.ce;
    assign bus.load_carry = lcy  & bus.ce;
    assign bus.init_carry = icy  & bus.ce;
    assign bus.sel_adr    = sa;
    assign bus.sel_ual    = sual;
    assign bus.ADR_JUMP   = ir_q[5:0];
`ifdef UC_FSM_STEP_EN
    assign bus.halted     = hlt & bus.ce;
`else
    logic unused_hlt;
    assign unused_hlt     = hlt;
`endif
endmodule

// File: tb/tb_uc_fsm.sv
// tb_uc_fsm: self-checking bench for uc_fsm (directed scenarios plus a
// randomized run against an instruction-timeline reference model).
module tb_uc_fsm;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uc_fsm_if bus ();
    uc_fsm dut (.clk(clk), .rst(rst), .bus(bus.master));

    // bit order: clear_PC load_PC enable_PC sel_adr mem_ce mem_we
    //            load_accu load_carry init_carry sel_ual ADR_JUMP[5:0]
    wire [15:0] outs = {bus.clear_PC, bus.load_PC, bus.enable_PC, bus.sel_adr,
                        bus.mem_ce, bus.mem_we, bus.load_accu, bus.load_carry,
                        bus.init_carry, bus.sel_ual, bus.ADR_JUMP};

    function automatic logic [15:0] pk(input logic cl, lp, en, sa, mc, mw,
                                       la, lc, ic, su, input logic [5:0] adr);
        return {cl, lp, en, sa, mc, mw, la, lc, ic, su, adr};
    endfunction

    task automatic drive(input logic r, input logic c, input logic [7:0] d, input logic cy);
        rst = r;
        bus.ce = c;
        bus.data_in = d;
        bus.carry = cy;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        drive(1, 1, 8'h00, 0);
        tick;
        drive(0, 1, 8'h00, 0);
        checks++;
        if (outs !== pk(1,0,1,0,0,0,0,0,1,0,0)) begin
            errors++; $display("FAIL reset_init got %h exp %h", outs, pk(1,0,1,0,0,0,0,0,1,0,0));
        end
        drive(0, 0, 8'h00, 1);
        checks++;
        if (outs !== 16'h0000) begin
            errors++; $display("FAIL reset_init_ce0 got %h exp %h", outs, 16'h0000);
        end
        drive(0, 1, 8'h00, 0);
        tick;
        checks++;
        if (outs !== pk(0,0,0,0,1,0,0,0,0,0,0)) begin
            errors++; $display("FAIL reset_fetch got %h exp %h", outs, pk(0,0,0,0,1,0,0,0,0,0,0));
        end
    endtask

    task automatic test_add;
        tick;
        drive(0, 1, 8'h45, 0);
        checks++;
        if (outs !== pk(0,0,1,0,0,0,0,0,0,0,0)) begin
            errors++; $display("FAIL add_decode got %h exp %h", outs, pk(0,0,1,0,0,0,0,0,0,0,0));
        end
        tick;
        drive(0, 1, 8'hC0, 0);
        checks++;
        if (outs !== pk(0,0,0,1,1,0,0,0,0,0,5)) begin
            errors++; $display("FAIL add_fetch_op got %h exp %h", outs, pk(0,0,0,1,1,0,0,0,0,0,5));
        end
        tick;
        checks++;
        if (outs !== pk(0,0,0,0,0,0,1,1,0,1,5)) begin
            errors++; $display("FAIL add_exe got %h exp %h", outs, pk(0,0,0,0,0,0,1,1,0,1,5));
        end
        tick;
        checks++;
        if (outs !== pk(0,0,0,0,1,0,0,0,0,0,5)) begin
            errors++; $display("FAIL add_back_fetch got %h exp %h", outs, pk(0,0,0,0,1,0,0,0,0,0,5));
        end
    endtask

    task automatic test_sta;
        tick;
        drive(0, 1, 8'h8A, 1);
        tick;
        drive(0, 1, 8'h00, 1);
        checks++;
        if (outs !== pk(0,0,0,1,1,1,0,0,0,0,10)) begin
            errors++; $display("FAIL sta_exe got %h exp %h", outs, pk(0,0,0,1,1,1,0,0,0,0,10));
        end
        tick;
        checks++;
        if (outs !== pk(0,0,0,0,1,0,0,0,0,0,10)) begin
            errors++; $display("FAIL sta_one_cycle got %h exp %h", outs, pk(0,0,0,0,1,0,0,0,0,0,10));
        end
    endtask

    task automatic test_jcc;
        tick;
        drive(0, 1, 8'hFF, 0);
        tick;
        checks++;
        if (outs !== pk(0,1,0,0,0,0,0,0,0,0,63)) begin
            errors++; $display("FAIL jcc_c0 got %h exp %h", outs, pk(0,1,0,0,0,0,0,0,0,0,63));
        end
        drive(0, 1, 8'h00, 1);
        checks++;
        if (outs !== pk(0,0,0,0,0,0,0,0,1,0,63)) begin
            errors++; $display("FAIL jcc_c1 got %h exp %h", outs, pk(0,0,0,0,0,0,0,0,1,0,63));
        end
        tick;
        checks++;
        if (outs !== pk(0,0,0,0,1,0,0,0,0,0,63)) begin
            errors++; $display("FAIL jcc_back_fetch got %h exp %h", outs, pk(0,0,0,0,1,0,0,0,0,0,63));
        end
    endtask

    task automatic test_ce_stall;
        tick;
        drive(0, 1, 8'h13, 0);
        tick;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 8'($urandom), 1);
            checks++;
            if (outs !== pk(0,0,0,1,0,0,0,0,0,0,19)) begin
                errors++; $display("FAIL stall_%0d got %h exp %h", i, outs, pk(0,0,0,1,0,0,0,0,0,0,19));
            end
            tick;
        end
        drive(0, 1, 8'h00, 0);
        checks++;
        if (outs !== pk(0,0,0,1,1,0,0,0,0,0,19)) begin
            errors++; $display("FAIL stall_resume got %h exp %h", outs, pk(0,0,0,1,1,0,0,0,0,0,19));
        end
        tick;
        checks++;
        if (outs !== pk(0,0,0,0,0,0,1,0,0,0,19)) begin
            errors++; $display("FAIL stall_nor_exe got %h exp %h", outs, pk(0,0,0,0,0,0,1,0,0,0,19));
        end
        tick;
    endtask

    task automatic test_reset_mid;
        tick;
        drive(0, 1, 8'h8A, 0);
        tick;
        drive(1, 1, 8'h00, 0);
        tick;
        drive(0, 1, 8'h00, 0);
        checks++;
        if (outs !== pk(1,0,1,0,0,0,0,0,1,0,0)) begin
            errors++; $display("FAIL reset_mid got %h exp %h", outs, pk(1,0,1,0,0,0,0,0,1,0,0));
        end
        tick;
    endtask

`ifdef UC_FSM_STEP_EN
    task automatic test_step;
        bus.step = 1'b0;
        drive(1, 1, 8'h00, 0);
        tick;
        drive(0, 1, 8'h00, 0);
        tick;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.halted, outs} !== {1'b1, 16'h0000}) begin
                errors++; $display("FAIL step_halt_%0d got %h exp %h", i, {bus.halted, outs}, {1'b1, 16'h0000});
            end
            tick;
        end
        bus.step = 1'b1;
        #1;
        checks++;
        if ({bus.halted, outs} !== {1'b0, pk(0,0,0,0,1,0,0,0,0,0,0)}) begin
            errors++; $display("FAIL step_go got %h exp %h", {bus.halted, outs}, {1'b0, pk(0,0,0,0,1,0,0,0,0,0,0)});
        end
        tick;
        bus.step = 1'b0;
        drive(0, 1, 8'h8A, 0);
        checks++;
        if (bus.halted !== 1'b0) begin
            errors++; $display("FAIL step_decode_halted got %b exp 0", bus.halted);
        end
        tick;
        tick;
        drive(0, 1, 8'h00, 0);
        checks++;
        if ({bus.halted, outs} !== {1'b1, pk(0,0,0,0,0,0,0,0,0,0,10)}) begin
            errors++; $display("FAIL step_rehalt got %h exp %h", {bus.halted, outs}, {1'b1, pk(0,0,0,0,0,0,0,0,0,0,10)});
        end
        bus.step = 1'b1;
    endtask
`endif

    // reference: an instruction is a timeline of cycles, pos -1 = INIT,
    // 0 fetch, 1 decode, then 1 (STA/JCC) or 2 (NOR/ADD) execute cycles
    task automatic test_random;
        int         pos = -1;
        logic [7:0] ir  = 8'h00;
        logic [15:0] e;
        logic       r, c, cy;
        logic [7:0] d;
        drive(1, 1, 8'h00, 0);
        tick;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            c  = ($urandom_range(0, 4) != 0);
            d  = 8'($urandom);
            cy = 1'($urandom);
            drive(r, c, d, cy);
            if (pos < 0) e = pk(1,0,1,0,0,0,0,0,1,0,ir[5:0]);
            else if (pos == 0) e = pk(0,0,0,0,1,0,0,0,0,0,ir[5:0]);
            else if (pos == 1) e = pk(0,0,1,0,0,0,0,0,0,0,ir[5:0]);
            else if (pos == 3) e = pk(0,0,0,0,0,0,1,ir[7:6] == 2'b01,0,ir[6],ir[5:0]);
            else if (ir[7:6] == 2'b10) e = pk(0,0,0,1,1,1,0,0,0,0,ir[5:0]);
            else if (ir[7:6] == 2'b11) e = pk(0,!cy,0,0,0,0,0,0,cy,0,ir[5:0]);
            else e = pk(0,0,0,1,1,0,0,0,0,0,ir[5:0]);
            if (!c) e = e & 16'h107F;
            checks++;
            if (outs !== e) begin
                errors++; $display("FAIL random_%0d pos %0d ir %h got %h exp %h", n, pos, ir, outs, e);
            end
            if (r) begin
                pos = -1;
                ir  = 8'h00;
            end else if (c) begin
                if (pos == 1) begin
                    ir  = d;
                    pos = 2;
                end else if (pos == 3 || (pos == 2 && ir[7])) pos = 0;
                else pos++;
            end
            tick;
        end
    endtask

    initial begin
`ifdef UC_FSM_STEP_EN
        bus.step = 1'b1;
`endif
        drive(1, 1, 8'h00, 0);
        @(negedge clk);
        test_reset;
        test_add;
        test_sta;
        test_jcc;
        test_ce_stall;
        test_reset_mid;
`ifdef UC_FSM_STEP_EN
        test_step;
`endif
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
